// File: rtl/cpu_loader.sv
// cpu_loader: framed serial loader for the Forth CPU instruction RAM.
// Frame = 0xA5, LEN_HI, LEN_LO, LEN x {HI, LO}, CSUM, where CSUM is the XOR
// of every byte after the sync byte. The CPU is held in reset until a frame
// with a matching checksum has been fully written.
module cpu_loader #(
   parameter int width       = 16,
   parameter int iaddr_width = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             rx_data_i,
   input  logic                   rx_valid_i,
   output logic                   rx_ready_o,
   output logic [iaddr_width-1:0] imem_waddr_o,
   output logic [width-1:0]       imem_wdata_o,
   output logic                   imem_write_o,
   output logic                   cpu_reset_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o
);

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   // Largest legal LEN: a program that fills every RAM location.
   // LEN is 16 bits on the wire, so one extra bit keeps the compare exact.
   localparam logic [16:0] MAX_LEN   = 17'(1) << iaddr_width;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_CSUM,
      ST_RUN,
      ST_ERR
   } state_t;

   state_t                 state_q, state_d;
   logic [iaddr_width-1:0] addr_q, addr_d;
   logic [iaddr_width:0]   remain_q, remain_d;
   logic [7:0]             len_hi_q, len_hi_d;
   logic [7:0]             hi_q, hi_d;
   logic [7:0]             csum_q, csum_d;

   logic                   rx_ready_q;
   logic                   write_q, write_d;
   logic [iaddr_width-1:0] waddr_q, waddr_d;
   logic [width-1:0]       wdata_q, wdata_d;
   logic                   cpu_reset_q, busy_q, done_q, error_q;

   logic                   accept;
   logic [16:0]            len_full;

   assign accept   = rx_valid_i & rx_ready_q;
   assign len_full = {1'b0, len_hi_q, rx_data_i};

   // Next-state and datapath decode; everything only moves on an accepted byte.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      len_hi_d = len_hi_q;
      hi_d     = hi_q;
      csum_d   = csum_q;
      write_d  = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      if (accept) begin
         case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
               // A sync byte (re)starts a frame from address 0 with a clean checksum.
               if (rx_data_i == SYNC_BYTE) begin
                  state_d = ST_LEN_HI;
                  addr_d  = '0;
                  csum_d  = '0;
               end
            end
            ST_LEN_HI: begin
               len_hi_d = rx_data_i;
               csum_d   = csum_q ^ rx_data_i;
               state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               csum_d = csum_q ^ rx_data_i;
               if (len_full > MAX_LEN) begin
                  state_d = ST_ERR;
               end else if (len_full == 17'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  remain_d = len_full[iaddr_width:0];
                  state_d  = ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               hi_d    = rx_data_i;
               csum_d  = csum_q ^ rx_data_i;
               state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               csum_d   = csum_q ^ rx_data_i;
               write_d  = 1'b1;
               waddr_d  = addr_q;
               wdata_d  = {hi_q, rx_data_i};
               // The increment after the last word of a full-size frame is
               // never used: the next sync byte reloads the address.
               addr_d   = addr_q + 1'b1;
               remain_d = remain_q - 1'b1;
               state_d  = (remain_q == 1) ? ST_CSUM : ST_DATA_HI;
            end
            ST_CSUM: begin
               state_d = (rx_data_i == csum_q) ? ST_RUN : ST_ERR;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, datapath and registered status outputs derived from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remain_q    <= '0;
         len_hi_q    <= '0;
         hi_q        <= '0;
         csum_q      <= '0;
         rx_ready_q  <= 1'b0;
         write_q     <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remain_q    <= remain_d;
         len_hi_q    <= len_hi_d;
         hi_q        <= hi_d;
         csum_q      <= csum_d;
         rx_ready_q  <= 1'b1;
         write_q     <= write_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= (state_d != ST_RUN);
         busy_q      <= (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                        (state_d == ST_DATA_HI) || (state_d == ST_DATA_LO) ||
                        (state_d == ST_CSUM);
         done_q      <= (state_d == ST_RUN);
         error_q     <= (state_d == ST_ERR);
      end
   end

   assign rx_ready_o   = rx_ready_q;
   assign imem_write_o = write_q;
   assign imem_waddr_o = waddr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_reset_o  = cpu_reset_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Testbench for cpu_loader: frames are built as byte queues, a frame-level
// reference model predicts the RAM writes and final status, and a monitor
// collects the writes the DUT actually issues.
module tb_cpu_loader;

   localparam int W  = 16;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic [AW-1:0] imem_waddr;
   logic [W-1:0]  imem_wdata;
   logic          imem_write;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          error;

   cpu_loader #(.width(W), .iaddr_width(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .rx_ready_o   (rx_ready),
      .imem_waddr_o (imem_waddr),
      .imem_wdata_o (imem_wdata),
      .imem_write_o (imem_write),
      .cpu_reset_o  (cpu_reset),
      .busy_o       (busy),
      .done_o       (done),
      .error_o      (error)
   );

   always #5 clk = ~clk;

   int nvec  = 0;
   int nfail = 0;

   logic [7:0]       fr[$];   // frame under test
   logic [AW+W-1:0]  wq[$];   // writes observed from the DUT
   logic [AW+W-1:0]  eq[$];   // writes predicted by the model
   logic             exp_done;
   logic             exp_err;

   // Every cycle with the strobe high is one RAM write.
   always @(negedge clk) begin
      if (!reset && imem_write)
         wq.push_back({imem_waddr, imem_wdata});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_from(input int start, input int maxgap);
      for (int i = start; i < fr.size(); i++)
         send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic load_bytes(input logic [63:0] v, input int n);
      fr.delete();
      for (int i = 0; i < n; i++)
         fr.push_back(v[8*(n-1-i) +: 8]);
   endtask

   task automatic make_frame(input int len, input bit good);
      logic [7:0] cs;
      logic [7:0] b;
      fr.delete();
      fr.push_back(8'hA5);
      fr.push_back(8'(len >> 8));
      fr.push_back(8'(len));
      cs = 8'(len >> 8) ^ 8'(len);
      for (int k = 0; k < 2 * len; k++) begin
         b = 8'($urandom);
         fr.push_back(b);
         cs = cs ^ b;
      end
      fr.push_back(good ? cs : (cs ^ 8'h5A));
   endtask

   // Frame-level model: skip to the sync byte, read LEN, list the words that
   // land at addresses 0..LEN-1 and decide the verdict from the XOR checksum.
   task automatic model();
      int         i;
      int         len;
      logic [7:0] cs;
      logic [7:0] hi;
      logic [7:0] lo;
      eq.delete();
      i = 0;
      while (i < fr.size() && fr[i] != 8'hA5) i++;
      len = {fr[i+1], fr[i+2]};
      if (len > (1 << AW)) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
         return;
      end
      cs = fr[i+1] ^ fr[i+2];
      for (int k = 0; k < len; k++) begin
         hi = fr[i+3+2*k];
         lo = fr[i+4+2*k];
         cs = cs ^ hi ^ lo;
         eq.push_back({k[AW-1:0], hi, lo});
      end
      exp_done = (fr[i+3+2*len] == cs);
      exp_err  = !exp_done;
   endtask

   // Compare status right after the last byte, then every write in order.
   task automatic check_frame(input string name);
      model();
      chk({name, ".done"},      32'(done),      32'(exp_done));
      chk({name, ".error"},     32'(error),     32'(exp_err));
      chk({name, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
      chk({name, ".busy"},      32'(busy),      32'(0));
      chk({name, ".nwrites"},   32'(wq.size()), 32'(eq.size()));
      for (int k = 0; k < eq.size() && k < wq.size(); k++)
         chk({name, ".write"}, 32'(wq[k]), 32'(eq[k]));
      $display("frame %s: %0d bytes, %0d writes, done=%0b error=%0b",
               name, fr.size(), wq.size(), done, error);
      wq.delete();
   endtask

   task automatic chk_reset_values(input string name);
      chk({name, ".rx_ready"},   32'(rx_ready),   32'(0));
      chk({name, ".imem_write"}, 32'(imem_write), 32'(0));
      chk({name, ".imem_waddr"}, 32'(imem_waddr), 32'(0));
      chk({name, ".imem_wdata"}, 32'(imem_wdata), 32'(0));
      chk({name, ".cpu_reset"},  32'(cpu_reset),  32'(1));
      chk({name, ".busy"},       32'(busy),       32'(0));
      chk({name, ".done"},       32'(done),       32'(0));
      chk({name, ".error"},      32'(error),      32'(0));
   endtask

   initial begin
      // Reset values, then rx_ready rises on the first edge after release.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rx_ready_up", 32'(rx_ready), 32'(1));

      // Good 2-word load with the documented checksum 0x42.
      load_bytes(64'hA5_00_02_12_34_AB_CD_42, 8);
      send_from(0, 0);
      check_frame("good2");

      // Zero-length frame.
      load_bytes(64'hA5_00_00_00, 4);
      send_from(0, 0);
      check_frame("zero");

      // Bad checksum: the word is still written, then error.
      load_bytes(64'hA5_00_01_BE_EF_00, 6);
      send_from(0, 0);
      check_frame("badcs");

      // A good frame after an error clears it.
      make_frame(3, 1'b1);
      send_from(0, 0);
      check_frame("recover");

      // Oversize LEN: error right after LEN_LO, no writes.
      load_bytes(64'hA5_04_01, 3);
      send_from(0, 0);
      check_frame("oversize");

      // Reload while running, with leading garbage that must be ignored.
      make_frame(2, 1'b1);
      send_from(0, 0);
      check_frame("preload");
      make_frame(4, 1'b1);
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      chk("garbage.done", 32'(done), 32'(1));
      send_byte(8'hA5, 0);
      chk("reload.cpu_reset", 32'(cpu_reset), 32'(1));
      chk("reload.done",      32'(done),      32'(0));
      chk("reload.busy",      32'(busy),      32'(1));
      send_from(1, 0);
      check_frame("reload");

      // Maximum length fills every address.
      make_frame(1 << AW, 1'b1);
      send_from(0, 0);
      check_frame("full");

      // The documented good load with random valid gaps.
      for (int r = 0; r < 3; r++) begin
         load_bytes(64'hA5_00_02_12_34_AB_CD_42, 8);
         send_from(0, 7);
         check_frame("good2_gaps");
      end

      // Random frames with random gaps and random checksum verdicts.
      for (int r = 0; r < 6; r++) begin
         make_frame(int'($urandom_range(1, 9)), bit'($urandom_range(0, 1)));
         send_from(0, 7);
         check_frame("random");
      end

      // Reset after the DATA_HI byte: outputs return to reset values and the
      // half word is dropped.
      load_bytes(64'hA5_00_01_12, 4);
      send_from(0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_values("midreset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_byte(8'h34, 1);
      chk("midreset.nowrite", 32'(wq.size()), 32'(0));
      make_frame(2, 1'b1);
      send_from(0, 0);
      check_frame("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/cpu_loader.md
# cpu_loader

Serial program loader for the Forth CPU's instruction memory. Accepts a framed byte stream over a valid/ready interface, assembles big-endian 16-bit instruction words, and writes them sequentially into the instruction RAM's write port. It holds the CPU in reset while loading and releases it only after a frame with a correct checksum. It is the writer side of the CPU's instruction fetch path (`iaddr`/`idata`) and sits between the host UART receiver and the instruction RAM.

## Interface
- `width`, 16, instruction word width; fixed at 16 (two bytes per word)
- `iaddr_width`, 10, instruction address width; max program = 2^iaddr_width words

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader can accept a byte; byte consumed when `rx_valid & rx_ready` at posedge
- `imem_waddr`  out  iaddr_width  instruction RAM write address
- `imem_wdata`  out  width  instruction RAM write data
- `imem_write`  out  1  one-cycle write strobe
- `cpu_reset`  out  1  reset to the CPU core; high while no valid program is loaded
- `busy`  out  1  frame in progress
- `done`  out  1  last frame loaded with good checksum; CPU running
- `error`  out  1  last frame rejected

## Operation
- Frame: `0xA5`, LEN_HI, LEN_LO, then LEN words as HI,LO byte pairs, then CSUM.
- CSUM = XOR of LEN_HI, LEN_LO and every data byte. The sync byte is excluded.
- States:
  - IDLE: wait for `0xA5` -> LEN_HI; all other bytes discarded.
  - LEN_HI -> LEN_LO.
  - LEN_LO:
    - LEN > 2^iaddr_width -> ERR.
    - LEN == 0 -> CSUM.
    - otherwise -> DATA_HI.
  - DATA_HI: latch high byte -> DATA_LO.
  - DATA_LO: form word {HI,LO}, issue write, increment address, decrement remaining count. Count reaches 0 -> CSUM, else -> DATA_HI.
  - CSUM: match -> RUN, mismatch -> ERR.
  - RUN: `0xA5` -> LEN_HI (reload); other bytes ignored.
  - ERR: `0xA5` -> LEN_HI (retry); other bytes ignored.
- Write address restarts at 0 on every sync byte accepted in IDLE/RUN/ERR. Running checksum clears at the same time.
- Address is `iaddr_width` bits; LEN == 2^iaddr_width writes every location. No wrap beyond the final write.
- `cpu_reset` = 1 in every state except RUN. A sync byte accepted in RUN re-asserts it immediately (registered, next cycle).
- `busy` = 1 in LEN_HI..CSUM. `done` = 1 only in RUN. `error` = 1 only in ERR.
- RAM contents written by a rejected frame stay in RAM. The CPU never runs them until a good frame completes.
- `rx_valid` gaps of any length are allowed in any state. The FSM advances only on accepted bytes.

## Timing
- All outputs registered.
- Reset values:
  - `rx_ready`=0, `imem_write`=0, `imem_waddr`=0, `imem_wdata`=0
  - `cpu_reset`=1, `busy`=0, `done`=0, `error`=0
  - state IDLE
- `rx_ready` rises on the first clock edge after reset deasserts and stays 1. The loader accepts one byte per cycle with no back-pressure.
- Write strobe: `imem_write` pulses high for exactly one cycle. The pulse is in the cycle after the DATA_LO byte is accepted, with `imem_waddr`/`imem_wdata` valid in that cycle. Back-to-back words give writes on consecutive accepted-LO cycles.
- Status after the CSUM byte is accepted at edge N:
  - good checksum: at N+1, `cpu_reset`=0, `done`=1, `busy`=0
  - bad checksum: at N+1, `error`=1, `cpu_reset` stays 1
- Reset mid-frame (`reset` asserted at any point): FSM returns to IDLE immediately, `cpu_reset`=1, and any pending write strobe is cancelled.
- Latency per word: 2 accepted bytes; a full frame takes 4 + 2·LEN accepted bytes.

## Test plan
- Good 2-word load: A5 00 02 12 34 AB CD CSUM=(00^02^12^34^AB^CD)=0x42 -> writes 0x1234@0, 0xABCD@1, each a 1-cycle strobe. Then `done`=1 and `cpu_reset`=0 one cycle after CSUM.
- Zero-length frame: A5 00 00 00 -> no `imem_write`, `done`=1, `cpu_reset`=0.
- Bad checksum: A5 00 01 BE EF 00 -> write 0xBEEF@0, then `error`=1, `cpu_reset` stays 1. A following good frame clears `error` and sets `done`.
- Oversize: iaddr_width=10, A5 04 01 -> ERR right after LEN_LO with no writes. LEN=0x0400 is accepted and writes addresses 0..1023.
- Reload while running: after a good load, send A5 -> `cpu_reset`=1 next cycle, `done`=0, `busy`=1, and the new frame writes from address 0. Leading garbage bytes (00 FF) before A5 are ignored.
- Random `rx_valid` gaps of 0-7 cycles on the good-load case produce identical writes. `reset` pulsed after the DATA_HI byte returns all outputs to their reset values and drops any partial word.
